// File: rtl/fm_ctrl_pkg.sv
// Shared definitions for the FM receive control path: FSM encoding, sync bytes, defaults.
package fm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC1 = 2'd1,
    ST_LOAD  = 2'd2,
    ST_FLUSH = 2'd3
  } seq_state_t;

  localparam logic [7:0] SYNC_BYTE0 = 8'hA5;
  localparam logic [7:0] SYNC_BYTE1 = 8'h5A;

  localparam int unsigned DEF_WIDTH     = 16;
  localparam int unsigned DEF_FRAME_LEN = 256;
  localparam int unsigned DEF_GAP_MAX   = 1023;

endpackage

// File: rtl/sample_hold_reg.sv
// One-entry hold register with ready/valid output and sticky overrun on a dropped load.
module sample_hold_reg #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          overrun
);

  logic xfer;

  assign xfer = valid & ready;

  // Capture when empty or draining this cycle; otherwise drop and flag overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      data    <= '0;
      overrun <= 1'b0;
    end else begin
      if (load && (!valid || xfer)) begin
        data  <= load_data;
        valid <= 1'b1;
      end else if (xfer) begin
        valid <= 1'b0;
      end
      if (load && valid && !xfer) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fm_rx_sequencer.sv
// Frames UART bytes behind an A5/5A sync word, feeds the merger, and hands merged samples
// to the demodulator through a one-entry hold register.
module fm_rx_sequencer
  import fm_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned FRAME_LEN = DEF_FRAME_LEN,
  parameter int unsigned GAP_MAX   = DEF_GAP_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_valid_i,
  input  logic [7:0]         rx_data_i,
  output logic               merge_start_o,
  output logic [7:0]         merge_byte_o,
  input  logic               merge_finished_i,
  input  logic [2*WIDTH-1:0] merge_data_i,
  input  logic               demod_ready_i,
  output logic               demod_valid_o,
  output logic [2*WIDTH-1:0] demod_data_o,
  output logic               frame_done_o,
  output logic               overrun_o,
  output logic               timeout_o,
  output logic               busy_o
);

  localparam int unsigned DW    = 2 * WIDTH;
  localparam int unsigned SMP_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned GAP_W = $clog2(GAP_MAX + 1);

  seq_state_t       state;
  logic [SMP_W-1:0] smp_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             sample_evt;

  // Merger results only count toward a frame while loading.
  assign sample_evt = merge_finished_i && (state == ST_LOAD);

  sample_hold_reg #(
    .DW (DW)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (sample_evt),
    .load_data (merge_data_i),
    .ready     (demod_ready_i),
    .valid     (demod_valid_o),
    .data      (demod_data_o),
    .overrun   (overrun_o)
  );

  // Sequencer FSM with byte forwarding, frame counting and inter-byte gap watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      smp_cnt       <= '0;
      gap_cnt       <= '0;
      merge_start_o <= 1'b0;
      merge_byte_o  <= '0;
      frame_done_o  <= 1'b0;
      timeout_o     <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      merge_start_o <= 1'b0;
      frame_done_o  <= 1'b0;
      timeout_o     <= 1'b0;
      case (state)
        ST_IDLE: begin
          gap_cnt <= '0;
          if (rx_valid_i && (rx_data_i == SYNC_BYTE0)) begin
            state  <= ST_SYNC1;
            busy_o <= 1'b1;
          end
        end
        ST_SYNC1: begin
          if (rx_valid_i) begin
            gap_cnt <= '0;
            if (rx_data_i == SYNC_BYTE1) begin
              state <= ST_LOAD;
            end else if (rx_data_i != SYNC_BYTE0) begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end
          end else if (gap_cnt == GAP_W'(GAP_MAX - 1)) begin
            timeout_o <= 1'b1;
            gap_cnt   <= '0;
            smp_cnt   <= '0;
            state     <= ST_IDLE;
            busy_o    <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        ST_LOAD: begin
          if (rx_valid_i) begin
            merge_start_o <= 1'b1;
            merge_byte_o  <= rx_data_i;
          end
          if (sample_evt && (smp_cnt == SMP_W'(FRAME_LEN - 1))) begin
            smp_cnt <= '0;
            gap_cnt <= '0;
            state   <= ST_FLUSH;
          end else begin
            if (sample_evt) begin
              smp_cnt <= smp_cnt + SMP_W'(1);
            end
            if (rx_valid_i) begin
              gap_cnt <= '0;
            end else if (gap_cnt == GAP_W'(GAP_MAX - 1)) begin
              timeout_o <= 1'b1;
              gap_cnt   <= '0;
              smp_cnt   <= '0;
              state     <= ST_IDLE;
              busy_o    <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
        end
        ST_FLUSH: begin
          if (!demod_valid_o) begin
            frame_done_o <= 1'b1;
            state        <= ST_IDLE;
            busy_o       <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fm_rx_sequencer.sv
// Self-checking bench for fm_rx_sequencer (FRAME_LEN=4, default WIDTH and GAP_MAX).
module tb_fm_rx_sequencer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DW    = 2 * WIDTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid_i;
  logic [7:0]    rx_data_i;
  logic          merge_start_o;
  logic [7:0]    merge_byte_o;
  logic          merge_finished_i;
  logic [DW-1:0] merge_data_i;
  logic          demod_ready_i;
  logic          demod_valid_o;
  logic [DW-1:0] demod_data_o;
  logic          frame_done_o;
  logic          overrun_o;
  logic          timeout_o;
  logic          busy_o;

  fm_rx_sequencer #(
    .WIDTH     (WIDTH),
    .FRAME_LEN (4),
    .GAP_MAX   (1023)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rx_valid_i       (rx_valid_i),
    .rx_data_i        (rx_data_i),
    .merge_start_o    (merge_start_o),
    .merge_byte_o     (merge_byte_o),
    .merge_finished_i (merge_finished_i),
    .merge_data_i     (merge_data_i),
    .demod_ready_i    (demod_ready_i),
    .demod_valid_o    (demod_valid_o),
    .demod_data_o     (demod_data_o),
    .frame_done_o     (frame_done_o),
    .overrun_o        (overrun_o),
    .timeout_o        (timeout_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } bexp_t;

  bexp_t         byte_q[$];
  logic [DW-1:0] demod_q[$];

  typedef struct packed {
    logic [47:0] bytes;
    logic [5:0]  fwd;
    logic [2:0]  n;
    logic        busy;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    rx_valid_i       = 1'b0;
    rx_data_i        = 8'h00;
    merge_finished_i = 1'b0;
    merge_data_i     = '0;
    demod_ready_i    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fwd);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    if (fwd) byte_q.push_back('{data: b, cyc: cyc});
    tick();
    rx_valid_i = 1'b0;
  endtask

  task automatic merge(input logic [DW-1:0] d, input logic accept);
    merge_finished_i = 1'b1;
    merge_data_i     = d;
    if (accept) demod_q.push_back(d);
    tick();
    merge_finished_i = 1'b0;
  endtask

  task automatic count_done(input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (frame_done_o) cnt++;
    end
  endtask

  // Scoreboard: byte strobes must match pushed bytes one cycle later; transfers match samples.
  always @(negedge clk) begin
    if (merge_start_o) begin
      if (byte_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strobe: got byte 0x%0h expected no strobe", merge_byte_o);
      end else begin
        bexp_t e;
        e = byte_q.pop_front();
        chk("strobe_byte", 64'(merge_byte_o), 64'(e.data));
        chk("strobe_latency", 64'(cyc), 64'(e.cyc + 1));
      end
    end
    if (demod_valid_o && demod_ready_i) begin
      if (demod_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_xfer: got 0x%0h expected no transfer", demod_data_o);
      end else begin
        logic [DW-1:0] d;
        d = demod_q.pop_front();
        chk("demod_data", 64'(demod_data_o), 64'(d));
      end
    end
  end

  function automatic logic [63:0] all_outs();
    return 64'({merge_start_o, merge_byte_o, demod_valid_o, demod_data_o,
                frame_done_o, overrun_o, timeout_o, busy_o});
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int first;

    vecs[0] = '{bytes: 48'hA55A_0102_0304, fwd: 6'b111100, n: 3'd6, busy: 1'b1};
    vecs[1] = '{bytes: 48'hA5A5_5A11_0000, fwd: 6'b001000, n: 3'd4, busy: 1'b1};
    vecs[2] = '{bytes: 48'hA533_0000_0000, fwd: 6'b000000, n: 3'd2, busy: 1'b0};
    vecs[3] = '{bytes: 48'h5AA5_0000_0000, fwd: 6'b000000, n: 3'd2, busy: 1'b1};
    vecs[4] = '{bytes: 48'h1234_0000_0000, fwd: 6'b000000, n: 3'd2, busy: 1'b0};
    vecs[5] = '{bytes: 48'hA55A_A55A_0000, fwd: 6'b001100, n: 3'd4, busy: 1'b1};

    // Reset state with busy inputs held.
    do_reset();
    rst = 1'b1; rx_valid_i = 1'b1; rx_data_i = 8'hA5; merge_finished_i = 1'b1;
    tick();
    chk("reset_outputs", all_outs(), 64'd0);
    do_reset();

    // Sync/forwarding vectors.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int i = 0; i < int'(vecs[v].n); i++) begin
        send_byte(vecs[v].bytes[47-8*i -: 8], vecs[v].fwd[i]);
        tick();
      end
      tick();
      tick();
      chk($sformatf("vec%0d_busy", v), 64'(busy_o), 64'(vecs[v].busy));
      chk($sformatf("vec%0d_pending_strobes", v), 64'(byte_q.size()), 64'd0);
    end

    // Full frame with ready held high, samples back to back.
    do_reset();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    demod_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) merge(32'hC0DE_0000 + 32'(k), 1'b1);
    chk("frame_flush_busy", 64'(busy_o), 64'd1);
    count_done(8, cnt);
    chk("frame_done_pulses", 64'(cnt), 64'd1);
    chk("frame_idle", 64'(busy_o), 64'd0);
    chk("frame_no_overrun", 64'(overrun_o), 64'd0);
    chk("frame_xfers_left", 64'(demod_q.size()), 64'd0);

    // Overrun: second sample dropped while first is held, dropped sample still counted.
    do_reset();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    merge(32'h1111_2222, 1'b1);
    merge(32'h3333_4444, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ovr_valid", 64'(demod_valid_o), 64'd1);
      chk("ovr_hold_data", 64'(demod_data_o), 64'h1111_2222);
    end
    chk("ovr_flag", 64'(overrun_o), 64'd1);
    demod_ready_i = 1'b1;
    tick();
    demod_ready_i = 1'b0;
    chk("ovr_drained", 64'(demod_valid_o), 64'd0);
    chk("ovr_sticky", 64'(overrun_o), 64'd1);
    demod_ready_i = 1'b1;
    merge(32'h5555_6666, 1'b1);
    merge(32'h7777_8888, 1'b1);
    count_done(8, cnt);
    chk("ovr_frame_done", 64'(cnt), 64'd1);
    chk("ovr_sticky_after_frame", 64'(overrun_o), 64'd1);

    // Gap timeout in LOAD with a sample held.
    do_reset();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    merge_finished_i = 1'b1;
    merge_data_i     = 32'hDEAD_BEEF;
    demod_q.push_back(32'hDEAD_BEEF);
    first = 0;
    for (int i = 1; i <= 1100; i++) begin
      tick();
      merge_finished_i = 1'b0;
      if (timeout_o) begin
        first = i;
        break;
      end
    end
    chk("timeout_cycle", 64'(first), 64'd1023);
    chk("timeout_idle", 64'(busy_o), 64'd0);
    chk("timeout_held_valid", 64'(demod_valid_o), 64'd1);
    chk("timeout_held_data", 64'(demod_data_o), 64'hDEAD_BEEF);
    tick();
    chk("timeout_pulse_width", 64'(timeout_o), 64'd0);
    demod_ready_i = 1'b1;
    tick();
    tick();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    for (int k = 0; k < 3; k++) merge(32'hABC0_0000 + 32'(k), 1'b1);
    count_done(6, cnt);
    chk("timeout_cnt_cleared_3", 64'(cnt), 64'd0);
    merge(32'hABC0_0003, 1'b1);
    count_done(6, cnt);
    chk("timeout_cnt_cleared_4", 64'(cnt), 64'd1);

    // Reset in the middle of LOAD overrides a coincident byte and sample.
    do_reset();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    send_byte(8'h77, 1'b1);
    merge(32'h0BAD_F00D, 1'b0);
    tick();
    chk("midreset_held", 64'(demod_valid_o), 64'd1);
    rst = 1'b1; rx_valid_i = 1'b1; rx_data_i = 8'h99; merge_finished_i = 1'b1;
    tick();
    chk("midreset_outputs", all_outs(), 64'd0);
    rst = 1'b0; rx_valid_i = 1'b0; merge_finished_i = 1'b0;
    count_done(10, cnt);
    chk("midreset_no_done", 64'(cnt), 64'd0);
    chk("midreset_idle", 64'(busy_o), 64'd0);

    chk("end_pending_strobes", 64'(byte_q.size()), 64'd0);
    chk("end_pending_xfers", 64'(demod_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fm_rx_sequencer.md
FM_RX_SEQUENCER -- requirements
Module: fm_rx_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the I or Q component width; a merged sample is 2*WIDTH bits.
REQ-002 SHALL have parameter FRAME_LEN, default 256, meaning the number of merged samples per frame.
REQ-003 SHALL have parameter GAP_MAX, default 1023, meaning the maximum idle cycles allowed between bytes inside a frame.
REQ-004 SHALL have port clk  input  1  single system clock; all logic rises on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port rx_valid_i  input  1  one-cycle strobe: UART byte available.
REQ-007 SHALL have port rx_data_i  input  8  UART byte, valid when rx_valid_i=1.
REQ-008 SHALL have port merge_start_o  output  1  byte strobe to the merger.
REQ-009 SHALL have port merge_byte_o  output  8  byte to the merger, valid when merge_start_o=1.
REQ-010 SHALL have port merge_finished_i  input  1  one-cycle pulse: merged sample ready.
REQ-011 SHALL have port merge_data_i  input  2*WIDTH  merged sample, valid with merge_finished_i.
REQ-012 SHALL have port demod_ready_i  input  1  demodulator accepts a sample this cycle.
REQ-013 SHALL have port demod_valid_o  output  1  sample offered to the demodulator.
REQ-014 SHALL have port demod_data_o  output  2*WIDTH  sample offered to the demodulator.
REQ-015 SHALL have ports frame_done_o, overrun_o, timeout_o, busy_o  output  1 each  frame-complete pulse, sticky overrun, timeout pulse, not-IDLE.

Function
REQ-016 SHALL implement states IDLE, SYNC1, LOAD, FLUSH.
REQ-017 SHALL move from IDLE to SYNC1 on an rx byte 0xA5; any other byte stays in IDLE.
REQ-018 SHALL move from SYNC1 to LOAD on byte 0x5A; on 0xA5 it stays in SYNC1; any other byte returns it to IDLE.
REQ-019 SHALL, in LOAD only, forward each rx byte as merge_start_o=1 and merge_byte_o=rx_data_i in the cycle after rx_valid_i (1-cycle latency); no bytes are forwarded in other states.
REQ-020 SHALL capture merge_data_i into a one-entry hold register on merge_finished_i and increment the sample counter (0..FRAME_LEN-1).
REQ-021 SHALL drive demod_valid_o high while the hold register is full; the transfer occurs when demod_valid_o and demod_ready_i are both 1, emptying the register.
REQ-022 SHALL keep demod_data_o stable while demod_valid_o=1 and demod_ready_i=0.
REQ-023 SHALL, when merge_finished_i arrives while the register is full and not transferring this cycle, drop the new sample, keep the old one, set overrun_o sticky, and still count the dropped sample.
REQ-024 SHALL, when merge_finished_i coincides with a transfer, load the new sample with no overrun.
REQ-025 SHALL enter FLUSH when the FRAME_LEN-th sample is captured; in FLUSH it ignores rx bytes and waits until the hold register is empty, then pulses frame_done_o for 1 cycle and returns to IDLE.
REQ-026 SHALL run a gap counter in SYNC1 and LOAD that clears on rx_valid_i; when it reaches GAP_MAX it pulses timeout_o, clears the sample counter, and returns to IDLE; a held sample remains offered.
REQ-027 SHALL clear overrun_o only on rst.
REQ-028 SHALL size counters as $clog2(FRAME_LEN) and $clog2(GAP_MAX+1) bits; there is no wrap-around inside a frame.

Reset
REQ-029 SHALL, on rst=1 at posedge clk: state IDLE, counters 0, hold register empty, and all outputs 0 (including demod_data_o and merge_byte_o).
REQ-030 SHALL let rst override any event in the same cycle; reset mid-frame discards the partial frame without a frame_done_o pulse.

Structure
REQ-031 SHALL take the state encoding, sync bytes 0xA5/0x5A and default parameter values from the shared package fm_ctrl_pkg.
REQ-032 SHALL place the one-entry hold register plus ready/valid logic in the sub-module sample_hold_reg.

Verification
REQ-033 SHALL verify: bytes A5 5A then 4 bytes 01 02 03 04 -> four merge_start_o strobes, each 1 cycle after its rx_valid_i, carrying 01..04.
REQ-034 SHALL verify: bytes A5 A5 5A -> sync accepted; bytes A5 33 -> return to IDLE with no strobes.
REQ-035 SHALL verify: FRAME_LEN=4 with demod_ready_i=1 -> 4 transfers, then frame_done_o for 1 cycle, then IDLE.
REQ-036 SHALL verify: demod_ready_i=0 and two merge_finished_i pulses -> first sample held stable, overrun_o=1 and stays 1.
REQ-037 SHALL verify: 1023 idle cycles in LOAD -> timeout_o pulse, state IDLE, sample counter 0.
REQ-038 SHALL verify: rst asserted mid-LOAD -> next cycle all outputs 0, no frame_done_o pulse.
